// File: rtl/pulse_meter_pkg.sv
// Shared types and constants for the gated multi-channel pulse rate meter.
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2
  } meter_state_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  // Any mode value other than rise/fall counts both edges.
  function automatic logic edge_hit(input int mode, input logic cur, input logic prev);
    case (mode)
      EDGE_RISE: return cur & ~prev;
      EDGE_FALL: return ~cur & prev;
      default:   return cur ^ prev;
    endcase
  endfunction

endpackage

// File: rtl/pulse_chan.sv
// One pulse channel: synchroniser, edge detector, saturating live counter
// and the latched count/overflow presented at the end of each gate window.
module pulse_chan
  import pulse_meter_pkg::*;
#(
  parameter int COUNT_W   = 9,
  parameter int EDGE_MODE = EDGE_RISE
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               pulseIn,
  input  logic               countEn,
  input  logic               clearLive,
  input  logic               latch,
  output logic [COUNT_W-1:0] countOut,
  output logic               overflow
);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_hist;
  logic [COUNT_W-1:0] r_live;
  logic               r_live_ovf;
  logic [COUNT_W-1:0] r_count;
  logic               r_ovf;

  logic               w_edge;
  logic               w_hit;
  logic               w_sat;
  logic [COUNT_W-1:0] w_live_next;
  logic               w_ovf_next;

  assign w_edge = edge_hit(EDGE_MODE, r_sync2, r_hist);
  assign w_hit  = countEn & w_edge;
  assign w_sat  = &r_live;

  // The latch path sees the value including this cycle's edge so an edge
  // on the terminal gate cycle lands in the closing window.
  assign w_live_next = (w_hit && !w_sat) ? r_live + COUNT_W'(1) : r_live;
  assign w_ovf_next  = r_live_ovf | (w_hit & w_sat);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_hist     <= 1'b0;
      r_live     <= '0;
      r_live_ovf <= 1'b0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_sync1 <= pulseIn;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      if (latch) begin
        r_count <= w_live_next;
        r_ovf   <= w_ovf_next;
      end
      if (clearLive) begin
        r_live     <= '0;
        r_live_ovf <= 1'b0;
      end else begin
        r_live     <= w_live_next;
        r_live_ovf <= w_ovf_next;
      end
    end
  end

  assign countOut = r_count;
  assign overflow = r_ovf;

endmodule

// File: rtl/pulse_rate_meter.sv
// Gated pulse counter: FSM, gate timebase and strobe; per-channel counting
// lives in pulse_chan instances.
module pulse_rate_meter
  import pulse_meter_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int COUNT_W     = 9,
  parameter int GATE_CYCLES = 100000000,
  parameter int EDGE_MODE   = EDGE_RISE
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        enable,
  input  logic                        restart,
  input  logic [CHANNELS-1:0]         pulseIn,
  output logic [CHANNELS*COUNT_W-1:0] countOut,
  output logic                        countValid,
  output logic [CHANNELS-1:0]         overflow,
  output logic                        busy
);

  localparam int              GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  meter_state_e      r_state;
  logic              r_settle;
  logic [GATE_W-1:0] r_gate;
  logic              r_valid;
  logic              r_busy;

  logic              w_measure;
  logic              w_terminal;
  logic              w_leave;
  logic              w_latch;
  logic              w_clear;

  assign w_measure  = (r_state == MEASURE);
  assign w_terminal = w_measure && (r_gate == GATE_LAST);
  assign w_leave    = !enable || restart;
  // Leaving MEASURE wins over the terminal latch: the window is discarded.
  assign w_latch    = w_terminal && !w_leave;
  assign w_clear    = !w_measure || w_terminal;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state  <= IDLE;
      r_settle <= 1'b0;
      r_gate   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_valid <= w_latch;
      case (r_state)
        IDLE: begin
          r_gate   <= '0;
          r_settle <= 1'b0;
          if (enable) begin
            r_state <= SETTLE;
            r_busy  <= 1'b1;
          end
        end
        SETTLE: begin
          r_gate <= '0;
          if (!enable) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_settle <= 1'b0;
          end else if (restart) begin
            r_settle <= 1'b0;
          end else if (r_settle) begin
            r_state  <= MEASURE;
            r_settle <= 1'b0;
          end else begin
            r_settle <= 1'b1;
          end
        end
        MEASURE: begin
          if (!enable) begin
            r_state <= IDLE;
            r_gate  <= '0;
            r_busy  <= 1'b0;
          end else if (restart) begin
            r_state  <= SETTLE;
            r_gate   <= '0;
            r_settle <= 1'b0;
          end else if (w_terminal) begin
            r_gate <= '0;
          end else begin
            r_gate <= r_gate + GATE_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      pulse_chan #(
        .COUNT_W   (COUNT_W),
        .EDGE_MODE (EDGE_MODE)
      ) u_chan (
        .clk       (clk),
        .resetN    (resetN),
        .pulseIn   (pulseIn[gi]),
        .countEn   (w_measure),
        .clearLive (w_clear),
        .latch     (w_latch),
        .countOut  (countOut[gi*COUNT_W +: COUNT_W]),
        .overflow  (overflow[gi])
      );
    end
  endgenerate

  assign countValid = r_valid;
  assign busy       = r_busy;

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Scoreboard bench: two meters share stimulus (rise-only 3-bit, both-edge 4-bit).
module tb_pulse_rate_meter;

  localparam int GATE = 20;
  localparam int MAXA = 7;
  localparam int MAXB = 15;

  logic       clk = 1'b0;
  logic       resetN;
  logic       enable;
  logic       restart;
  logic [1:0] pulseIn;
  logic [5:0] count_a;
  logic [7:0] count_b;
  logic       valid_a, valid_b;
  logic [1:0] ovf_a, ovf_b;
  logic       busy_a, busy_b;

  pulse_rate_meter #(.CHANNELS(2), .COUNT_W(3), .GATE_CYCLES(GATE), .EDGE_MODE(0)) dut_a (
    .clk(clk), .resetN(resetN), .enable(enable), .restart(restart), .pulseIn(pulseIn),
    .countOut(count_a), .countValid(valid_a), .overflow(ovf_a), .busy(busy_a));

  pulse_rate_meter #(.CHANNELS(2), .COUNT_W(4), .GATE_CYCLES(GATE), .EDGE_MODE(2)) dut_b (
    .clk(clk), .resetN(resetN), .enable(enable), .restart(restart), .pulseIn(pulseIn),
    .countOut(count_b), .countValid(valid_b), .overflow(ovf_b), .busy(busy_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int a0, a1, aov;
    int b0, b1, bov;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_e;
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model state
  bit         measuring = 1'b0;
  int         base = 0;
  int         acc_r[2];
  int         acc_e[2];
  logic [1:0] prev_p = 2'b00;
  logic       prev_en = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_acc();
    for (int c = 0; c < 2; c++) begin
      acc_r[c] = 0;
      acc_e[c] = 0;
    end
  endtask

  task automatic drop_from(input int c);
    while (sb_q.size() > 0 && sb_q[$].cyc >= c) void'(sb_q.pop_back());
  endtask

  // Drive one cycle of inputs and advance the model; a window closes when
  // its last input slot is driven and its strobe is due three edges later.
  task automatic step(input logic [1:0] p);
    exp_t e;
    pulseIn = p;
    if (enable && !prev_en) begin
      measuring = 1'b1;
      base = cyc;
      clear_acc();
    end else if (!enable && prev_en) begin
      measuring = 1'b0;
      drop_from(cyc + 1);
    end else if (restart && measuring) begin
      base = cyc;
      clear_acc();
      drop_from(cyc + 1);
    end
    if (measuring && cyc > base) begin
      for (int c = 0; c < 2; c++) begin
        if (p[c] != prev_p[c]) begin
          acc_e[c]++;
          if (p[c]) acc_r[c]++;
        end
      end
      if ((cyc - base) % GATE == 0) begin
        e.cyc = cyc + 3;
        e.a0  = (acc_r[0] > MAXA) ? MAXA : acc_r[0];
        e.a1  = (acc_r[1] > MAXA) ? MAXA : acc_r[1];
        e.aov = ((acc_r[1] > MAXA) ? 2 : 0) + ((acc_r[0] > MAXA) ? 1 : 0);
        e.b0  = (acc_e[0] > MAXB) ? MAXB : acc_e[0];
        e.b1  = (acc_e[1] > MAXB) ? MAXB : acc_e[1];
        e.bov = ((acc_e[1] > MAXB) ? 2 : 0) + ((acc_e[0] > MAXB) ? 1 : 0);
        sb_q.push_back(e);
        clear_acc();
      end
    end
    prev_p  = p;
    prev_en = enable;
    tick();
  endtask

  function automatic logic [1:0] pat(input int kind, input int s);
    case (kind)
      1:       return {(s == 2 || s == 10), (s % 3 == 0 && s < 15)};
      2:       return {1'b0, (s % 2 == 0)};
      3:       return {(s == 19), 1'b0};
      4:       return {(s == 0), (s == 0)};
      5:       return {1'b0, (s < 6 && s % 2 == 0)};
      6:       return {1'b0, (s == 4)};
      default: return 2'b00;
    endcase
  endfunction

  task automatic run_slots(input int kind, input int n);
    for (int s = 0; s < n; s++) step(pat(kind, s));
  endtask

  // Output monitor: pops one expected window per strobe.
  always begin
    @(posedge clk);
    #1;
    if (resetN) begin
      if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        check_eq("missing_strobe", int'(valid_a), 1);
        void'(sb_q.pop_front());
      end
      if (valid_a) begin
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
          mon_e = sb_q.pop_front();
          $display("strobe cyc=%0d A ch0=%0d ch1=%0d ovf=%0d | B ch0=%0d ch1=%0d ovf=%0d",
                   cyc, count_a[2:0], count_a[5:3], ovf_a, count_b[3:0], count_b[7:4], ovf_b);
          check_eq("a_ch0", int'(count_a[2:0]), mon_e.a0);
          check_eq("a_ch1", int'(count_a[5:3]), mon_e.a1);
          check_eq("a_ovf", int'(ovf_a), mon_e.aov);
          check_eq("b_valid", int'(valid_b), 1);
          check_eq("b_ch0", int'(count_b[3:0]), mon_e.b0);
          check_eq("b_ch1", int'(count_b[7:4]), mon_e.b1);
          check_eq("b_ovf", int'(ovf_b), mon_e.bov);
          last_e = mon_e;
        end else begin
          check_eq("unexpected_strobe", int'(valid_a), 0);
        end
      end else if (valid_b) begin
        check_eq("b_unexpected_strobe", int'(valid_b), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    resetN  = 1'b0;
    enable  = 1'b0;
    restart = 1'b0;
    pulseIn = 2'b00;
    clear_acc();
    repeat (3) tick();
    check_eq("rst_count_a", int'(count_a), 0);
    check_eq("rst_ovf_a", int'(ovf_a), 0);
    check_eq("rst_valid_a", int'(valid_a), 0);
    check_eq("rst_busy_a", int'(busy_a), 0);
    check_eq("rst_count_b", int'(count_b), 0);
    resetN = 1'b1;
    run_slots(0, 2);
    check_eq("idle_busy", int'(busy_a), 0);

    // windows 0..5: idle, mixed, idle, saturating, terminal edge, boundary
    enable = 1'b1;
    step(2'b00);
    check_eq("busy_after_enable", int'(busy_a), 1);
    run_slots(0, 20);
    run_slots(1, 20);
    run_slots(0, 20);
    run_slots(2, 20);
    run_slots(3, 20);
    run_slots(4, 20);

    // restart mid-window after three edges
    run_slots(5, 10);
    restart = 1'b1;
    step(2'b00);
    restart = 1'b0;
    run_slots(1, 20);

    // restart on the terminal cycle suppresses the strobe
    run_slots(3, 20);
    step(2'b10);
    restart = 1'b1;
    step(2'b10);
    restart = 1'b0;
    run_slots(6, 20);
    run_slots(0, 4);

    // enable dropped mid-window
    run_slots(1, 8);
    enable = 1'b0;
    step(2'b00);
    check_eq("drop_busy", int'(busy_a), 0);
    check_eq("drop_hold_ch0", int'(count_a[2:0]), last_e.a0);
    check_eq("drop_hold_ch1", int'(count_a[5:3]), last_e.a1);
    run_slots(0, 25);

    // reset asserted mid-window after a non-zero latch
    enable = 1'b1;
    step(2'b00);
    run_slots(5, 20);
    run_slots(0, 8);
    check_eq("pre_reset_busy", int'(busy_a), 1);
    resetN = 1'b0;
    #2;
    check_eq("mid_rst_count_a", int'(count_a), 0);
    check_eq("mid_rst_ovf_a", int'(ovf_a), 0);
    check_eq("mid_rst_busy_a", int'(busy_a), 0);
    check_eq("mid_rst_count_b", int'(count_b), 0);
    sb_q.delete();
    measuring = 1'b0;
    enable    = 1'b0;
    prev_en   = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
    run_slots(0, 3);

    // normal operation after reset
    enable = 1'b1;
    step(2'b00);
    run_slots(1, 20);
    run_slots(0, 5);
    enable = 1'b0;
    run_slots(0, 3);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
